// File: rtl/stoch_pkg.sv
// Shared types and helpers for the stochastic decode path: FSM state encoding
// and the dual-rail sample-to-delta mapping.
package stoch_pkg;

  typedef enum logic [1:0] {
    STOCH_DEC_IDLE = 2'd0,
    STOCH_DEC_RUN  = 2'd1,
    STOCH_DEC_DONE = 2'd2
  } stoch_dec_state_e;

  // pos - neg as a 2-bit signed value; both rails high cancel to zero.
  function automatic logic signed [1:0] stoch_delta(input logic p, input logic n);
    logic signed [1:0] d;
    d = 2'sd0;
    if (p && !n) d = 2'sd1;
    else if (!p && n) d = -2'sd1;
    return d;
  endfunction

endpackage

// File: rtl/stoch_updown_acc.sv
// Signed up/down accumulator with synchronous clear (priority) and enable.
// sum_o exposes acc + delta so callers can capture the final sample's result.
module stoch_updown_acc #(
  parameter int WIDTH = 10
) (
  input  logic                    CLK,
  input  logic                    nRST,
  input  logic                    clr_i,
  input  logic                    en_i,
  input  logic signed [1:0]       delta_i,
  output logic        [WIDTH-1:0] acc_o,
  output logic        [WIDTH-1:0] sum_o
);

  logic [WIDTH-1:0] acc_q;
  logic [WIDTH-1:0] acc_d;

  assign sum_o = acc_q + {{(WIDTH-2){delta_i[1]}}, delta_i};
  assign acc_o = acc_q;

  always_comb begin
    acc_d = acc_q;
    if (clr_i)     acc_d = '0;
    else if (en_i) acc_d = sum_o;
  end

  always_ff @(posedge CLK) begin
    if (!nRST) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/stoch_decode_window.sv
// Dual-rail stochastic-to-binary decoder: sums (pos - neg) over 2^WINDOW_LOG2
// enabled samples and presents the signed total on y with a one-cycle done.
module stoch_decode_window #(
  parameter int WINDOW_LOG2 = 8,
  parameter int OUT_WIDTH   = WINDOW_LOG2 + 2
) (
  input  logic                 CLK,
  input  logic                 nRST,
  input  logic                 start,
  input  logic                 en,
  input  logic                 pos,
  input  logic                 neg,
  output logic                 busy,
  output logic                 done,
  output logic [OUT_WIDTH-1:0] y
);
  import stoch_pkg::*;

  if (OUT_WIDTH < WINDOW_LOG2 + 2) begin : g_width_check
    $error("stoch_decode_window: OUT_WIDTH must be >= WINDOW_LOG2+2");
  end

  localparam logic [WINDOW_LOG2-1:0] CNT_LAST = '1;

  stoch_dec_state_e       state_q, state_d;
  logic [WINDOW_LOG2-1:0] cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0]   y_q, y_d;
  logic                   acc_clr, acc_en;
  logic [OUT_WIDTH-1:0]   acc_val, acc_sum;
  logic signed [1:0]      delta;

  assign delta = stoch_delta(pos, neg);

  stoch_updown_acc #(.WIDTH(OUT_WIDTH)) u_acc (
    .CLK     (CLK),
    .nRST    (nRST),
    .clr_i   (acc_clr),
    .en_i    (acc_en),
    .delta_i (delta),
    .acc_o   (acc_val),
    .sum_o   (acc_sum)
  );

  // Accumulator is held at zero outside RUN, so every window starts clean.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    y_d     = y_q;
    acc_clr = 1'b0;
    acc_en  = 1'b0;
    case (state_q)
      STOCH_DEC_IDLE: begin
        acc_clr = 1'b1;
        cnt_d   = '0;
        if (start) state_d = STOCH_DEC_RUN;
      end
      STOCH_DEC_RUN: begin
        if (en) begin
          acc_en = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) begin
            y_d     = acc_sum;
            acc_clr = 1'b1;
            state_d = STOCH_DEC_DONE;
          end
        end
      end
      STOCH_DEC_DONE: begin
        acc_clr = 1'b1;
        cnt_d   = '0;
        state_d = start ? STOCH_DEC_RUN : STOCH_DEC_IDLE;
      end
      default: begin
        acc_clr = 1'b1;
        cnt_d   = '0;
        state_d = STOCH_DEC_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= STOCH_DEC_IDLE;
      cnt_q   <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      y_q     <= y_d;
    end
  end

  assign busy = (state_q == STOCH_DEC_RUN);
  assign done = (state_q == STOCH_DEC_DONE);
  assign y    = y_q;

  logic unused_acc;
  assign unused_acc = ^acc_val;

endmodule

// File: doc/stoch_decode_window.md
Name: stoch_decode_window

Overview:
Stochastic-to-binary decoder: converts a dual-rail (pos/neg) stochastic bitstream pair back into a signed fixed-point binary value. It counts ones over a window of 2^WINDOW_LOG2 enabled samples. It sits at the output boundary of stochastic datapaths (after saturating add/sub stages) and is the readback end of the stochastic encoding. Window start uses a start/done handshake.

Parameters:
WINDOW_LOG2, 8, log2 of samples per window (N = 2^WINDOW_LOG2); result has WINDOW_LOG2 fractional bits
OUT_WIDTH, WINDOW_LOG2+2, signed result width; must be >= WINDOW_LOG2+2, elaboration error otherwise

Ports:
CLK  input  1  clock, rising edge
nRST  input  1  reset, synchronous, active-low
start  input  1  request a new window; sampled on rising edge
en  input  1  sample enable; only cycles with en=1 count toward the window
pos  input  1  positive-rail stochastic bit
neg  input  1  negative-rail stochastic bit
busy  output  1  high while a window is in progress (state RUN)
done  output  1  one-cycle pulse: y valid and newly updated
y  output  OUT_WIDTH  signed two's-complement result = sum(pos-neg) over window; held until next done

Behaviour:
- Reset, on CLK edge with nRST=0: state=IDLE, acc=0, cnt=0, y=0, done=0, busy=0. Overrides all other inputs. Reset mid-window discards the partial window; no done.
- Per-sample delta = pos - neg in {-1, 0, +1}; pos=neg=1 gives 0. Delta applies only when state=RUN and en=1.
- acc: OUT_WIDTH signed. Range [-N, +N] always fits, so no saturation logic.
- cnt: WINDOW_LOG2 bits, counts enabled samples 0..N-1.
- FSM states:
  - IDLE: busy=0. start=1 -> RUN with acc<=0, cnt<=0.
  - RUN: busy=1. On edge with en=1: acc<=acc+delta, cnt<=cnt+1.
    - If en=1 and cnt==N-1: y<=acc+delta, done<=1, acc<=0, cnt<=0 (wrap), go to DONE.
    - en=0: hold acc and cnt.
    - start is ignored in RUN; no restart or abort.
  - DONE: done=1 for exactly this cycle, busy=0.
    - start=1 -> RUN with acc=0, cnt=0.
    - Otherwise -> IDLE.
- Latency: with start sampled at edge 0 and en held at 1, samples are taken at edges 1..N and done is high in the cycle after edge N. y is registered and changes only on that edge.
- Back-to-back: start held high gives a one-cycle DONE gap between windows. The sample present during the DONE cycle is not counted.
- Outputs are all registered. No combinational path from inputs to outputs.
- y interpretation: value = y / 2^WINDOW_LOG2, in [-1.0, +1.0].

Decomposition:
- Shared package stoch_pkg:
  - state enum localparams STOCH_DEC_IDLE=2'd0, STOCH_DEC_RUN=2'd1, STOCH_DEC_DONE=2'd2
  - function for 2-bit signed delta from (pos, neg)
- Sub-module stoch_updown_acc: clear/enable/delta -> signed OUT_WIDTH accumulator. Reusable by future windowed estimators.
- FSM and cnt live in the top.

Test Plan:
- WINDOW_LOG2=8; start pulse, en=1, pos=1, neg=0 for 256 cycles -> done after edge 256, y=+256 (10'h100), busy low during DONE.
- pos=1, neg=1 every cycle -> y=0. Then pos=0, neg=1 -> y=-256 (10'h300).
- pos toggling 1,0,1,0..., neg=0 -> y=+128. Then pos toggling, neg constant 1 -> y=-128 (10'h380).
- en alternating 1/0, pos=1, neg=0 -> done at ~512 cycles after start, y=+256. Pulse start mid-RUN -> no effect on count or done timing.
- nRST=0 at sample 100 of a window -> next cycle y=0, busy=0, done=0, state IDLE. A fresh window after reset gives the correct full result.
- start held high for 3 windows with pos fixed at 1 -> done every 257 cycles, each y=+256, no samples leak across windows.
